fosfor_nibble_regif: RTL and testbench

Host-side register interface for the PRESENT-80 engine on the TinyTapeout slot. Decodes the 2-bit address / 4-bit data nibble bus from io_in, assembles bytes, holds the 64-bit text and 80-bit key register file, and issues start to the cipher core. Returns either the status byte or the addressed register byte on io_out. It sits between the pad wrapper and the PRESENT round core.

---
 rtl/fosfor_nibble_regif_pkg.sv | 39 +++
 rtl/fosfor_nibble_regif_if.sv | 24 ++
 rtl/fosfor_nibble_assembler.sv | 41 ++++
 rtl/fosfor_nibble_regif.sv | 139 +++++++++++++
 tb/tb_fosfor_nibble_regif.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/fosfor_nibble_regif_pkg.sv
// rtl/fosfor_nibble_regif_pkg.sv - shared bus phases, command codes and register map for the nibble register interface
package fosfor_nibble_regif_pkg;

  // Bus phase carried on Address_b
  typedef enum logic [1:0] {
    ADDR_IDLE = 2'd0,
    ADDR_LOW  = 2'd1,
    ADDR_HIGH = 2'd2,
    ADDR_CMD  = 2'd3
  } addr_phase_e;

  // Command codes carried on DataIn_b during the CMD phase
  localparam logic [3:0] CMD_LATCH_ADDRESS = 4'd1;
  localparam logic [3:0] CMD_WRITE         = 4'd2;
  localparam logic [3:0] CMD_START         = 4'd3;
  localparam logic [3:0] CMD_WRITE_INC     = 4'd4;
  localparam logic [3:0] CMD_CLEAR         = 4'd5;

  // Register map
  localparam logic [7:0] TEXT_LAST     = 8'h07;
  localparam logic [7:0] KEY_OFFSET    = 8'h08;
  localparam logic [7:0] KEY_LAST      = 8'h11;
  localparam logic [7:0] TEST_REG_ADDR = 8'h20;

  // Status byte bit positions
  localparam int STATUS_READY_BIT = 0;
  localparam int STATUS_DONE_BIT  = 1;
  localparam int STATUS_ERR_BIT   = 2;

  function automatic logic [7:0] status_byte(input logic err, input logic done, input logic ready);
    logic [7:0] s;
    s = 8'h00;
    s[STATUS_ERR_BIT]   = err;
    s[STATUS_DONE_BIT]  = done;
    s[STATUS_READY_BIT] = ready;
    return s;
  endfunction

endpackage

// File: rtl/fosfor_nibble_regif_if.sv
// rtl/fosfor_nibble_regif_if.sv - host nibble bus and cipher core signals seen by the register interface
interface fosfor_nibble_regif_if;
  logic [1:0]  Address_b;
  logic [3:0]  DataIn_b;
  logic [7:0]  DataOut_b;
  logic [79:0] Key_b;
  logic [63:0] PlainText_b;
  logic        Start;
  logic        Ready;
  logic        Done;
  logic [63:0] CipherText_b;

  // Environment side: drives the host bus and the core status/result
  modport master (
    output Address_b, DataIn_b, Ready, Done, CipherText_b,
    input  DataOut_b, Key_b, PlainText_b, Start
  );

  // Register interface side
  modport slave (
    input  Address_b, DataIn_b, Ready, Done, CipherText_b,
    output DataOut_b, Key_b, PlainText_b, Start
  );
endinterface

// File: rtl/fosfor_nibble_assembler.sv
// rtl/fosfor_nibble_assembler.sv - nibble-to-byte buffer and bus phase decode
module fosfor_nibble_assembler
  import fosfor_nibble_regif_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] phase,
  input  logic [3:0] nibble,
  output logic [7:0] asm_byte,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  output logic       rd_phase
);

  logic [7:0] byte_buf_q, byte_buf_d;

  // Next buffer value: LOW fills the low nibble, HIGH the high nibble, others hold
  always_comb begin
    byte_buf_d = byte_buf_q;
    case (addr_phase_e'(phase))
      ADDR_LOW:  byte_buf_d[3:0] = nibble;
      ADDR_HIGH: byte_buf_d[7:4] = nibble;
      default:   byte_buf_d = byte_buf_q;
    endcase
  end

  // Buffer register; a reset mid-byte discards the partial byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) byte_buf_q <= 8'h00;
    else     byte_buf_q <= byte_buf_d;
  end

  // Commands act on the byte assembled by earlier phases
  always_comb begin
    asm_byte  = byte_buf_q;
    cmd_valid = (addr_phase_e'(phase) == ADDR_CMD);
    cmd_code  = nibble;
    rd_phase  = (addr_phase_e'(phase) == ADDR_LOW);
  end

endmodule

// File: rtl/fosfor_nibble_regif.sv
// rtl/fosfor_nibble_regif.sv - register file, command decode and read-back mux for the PRESENT-80 host bus
module fosfor_nibble_regif
  import fosfor_nibble_regif_pkg::*;
#(
  parameter bit TEST_REG_EN = 1'b1
) (
  input  logic                  Clk_k,
  input  logic                  Reset_r,
  fosfor_nibble_regif_if.slave  bus
);

  logic [7:0]  asm_byte;
  logic        cmd_valid;
  logic [3:0]  cmd_code;
  logic        rd_phase;

  logic [7:0]  addr_q, addr_d;
  logic [63:0] text_q, text_d;
  logic [79:0] key_q, key_d;
  logic [7:0]  test_q, test_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        start_q, start_d;
  logic [7:0]  dout_q, dout_d;

  logic        in_text, in_key, in_test;
  logic [5:0]  text_bit;
  logic [6:0]  key_bit;
  logic        is_write;
  logic [7:0]  rd_data;

  fosfor_nibble_assembler u_asm (
    .clk       (Clk_k),
    .rst       (Reset_r),
    .phase     (bus.Address_b),
    .nibble    (bus.DataIn_b),
    .asm_byte  (asm_byte),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .rd_phase  (rd_phase)
  );

  // Address decode of the current register pointer
  always_comb begin
    in_text  = (addr_q <= TEXT_LAST);
    in_key   = (addr_q >= KEY_OFFSET) && (addr_q <= KEY_LAST);
    in_test  = TEST_REG_EN && (addr_q == TEST_REG_ADDR);
    text_bit = {addr_q[2:0], 3'b000};
    key_bit  = 7'({addr_q - KEY_OFFSET, 3'b000});
    is_write = cmd_valid && ((cmd_code == CMD_WRITE) || (cmd_code == CMD_WRITE_INC));
  end

  // Command execution; a core Done is applied last so it overrides text writes and CLEAR of done
  always_comb begin
    addr_d  = addr_q;
    text_d  = text_q;
    key_d   = key_q;
    test_d  = test_q;
    err_d   = err_q;
    done_d  = done_q;
    start_d = 1'b0;

    if (is_write) begin
      if ((in_text || in_key) && !bus.Ready) begin
        err_d = 1'b1;
      end else if (in_text && bus.Done) begin
        err_d = 1'b1;
      end else if (in_text) begin
        text_d[text_bit +: 8] = asm_byte;
      end else if (in_key) begin
        key_d[key_bit +: 8] = asm_byte;
      end else if (in_test) begin
        test_d = asm_byte;
      end
    end

    if (cmd_valid) begin
      case (cmd_code)
        CMD_LATCH_ADDRESS: addr_d = asm_byte;
        CMD_WRITE_INC:     addr_d = addr_q + 8'd1;
        CMD_START: begin
          if (bus.Ready) begin
            start_d = 1'b1;
            done_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
        CMD_CLEAR: begin
          err_d  = 1'b0;
          done_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (bus.Done) begin
      text_d = bus.CipherText_b;
      done_d = 1'b1;
    end
  end

  // Read-back: LOW phase returns the addressed byte, every other phase the status byte
  always_comb begin
    rd_data = 8'h00;
    if (in_text)      rd_data = text_q[text_bit +: 8];
    else if (in_test) rd_data = test_q;
    dout_d = rd_phase ? rd_data : status_byte(err_q, done_q, bus.Ready);
  end

  // State registers
  always_ff @(posedge Clk_k or posedge Reset_r) begin
    if (Reset_r) begin
      addr_q  <= 8'h00;
      text_q  <= 64'h0;
      key_q   <= 80'h0;
      test_q  <= 8'h00;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      start_q <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      addr_q  <= addr_d;
      text_q  <= text_d;
      key_q   <= key_d;
      test_q  <= test_d;
      err_q   <= err_d;
      done_q  <= done_d;
      start_q <= start_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.DataOut_b   = dout_q;
  assign bus.Key_b       = key_q;
  assign bus.PlainText_b = text_q;
  assign bus.Start       = start_q;

endmodule

// File: tb/tb_fosfor_nibble_regif.sv
// tb/tb_fosfor_nibble_regif.sv - directed scoreboard bench for the nibble register interface
module tb_fosfor_nibble_regif;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [79:0] exp_q[$];
  string       tag_q[$];

  fosfor_nibble_regif_if bus_if ();

  fosfor_nibble_regif #(.TEST_REG_EN(1'b1)) dut (
    .Clk_k   (clk),
    .Reset_r (rst),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_val(input string tag, input logic [79:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_pop(input logic [79:0] obs);
    logic [79:0] e;
    string       t;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  task automatic bus(input logic [1:0] ph, input logic [3:0] nib);
    bus_if.Address_b = ph;
    bus_if.DataIn_b  = nib;
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    bus(2'd1, b[3:0]);
    bus(2'd2, b[7:4]);
  endtask

  task automatic cmd(input logic [3:0] c);
    bus(2'd3, c);
  endtask

  task automatic read_byte(input string tag, input logic [7:0] a, input logic [7:0] e);
    put_byte(a);
    cmd(4'd1);
    expect_val(tag, {72'h0, e});
    bus(2'd1, 4'h0);
    check_pop({72'h0, bus_if.DataOut_b});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  key_bytes [10];
    logic [63:0] text_val;
    logic [63:0] ct_val;
    logic [63:0] ct2_val;

    checks   = 0;
    failures = 0;
    key_bytes = '{8'hAA, 8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h90, 8'h78, 8'h56, 8'h34, 8'h12};
    text_val = 64'h1122334455667788;
    ct_val   = 64'h5579C1387B228445;
    ct2_val  = 64'hDEADBEEF01234567;

    rst                 = 1'b1;
    bus_if.Address_b    = 2'd0;
    bus_if.DataIn_b     = 4'h0;
    bus_if.Ready        = 1'b1;
    bus_if.Done         = 1'b0;
    bus_if.CipherText_b = 64'h0;
    repeat (2) @(posedge clk);
    #1;

    expect_val("reset_dout", 80'h0);  check_pop({72'h0, bus_if.DataOut_b});
    expect_val("reset_start", 80'h0); check_pop({79'h0, bus_if.Start});
    expect_val("reset_key", 80'h0);   check_pop(bus_if.Key_b);
    expect_val("reset_text", 80'h0);  check_pop({16'h0, bus_if.PlainText_b});
    rst = 1'b0;

    bus(2'd0, 4'h0);
    expect_val("idle_status", 80'h01);
    bus(2'd0, 4'h0);
    check_pop({72'h0, bus_if.DataOut_b});

    put_byte(8'h20); cmd(4'd1);
    put_byte(8'hA5); cmd(4'd2);
    expect_val("test_reg_read", 80'hA5);
    bus(2'd1, 4'h0);
    check_pop({72'h0, bus_if.DataOut_b});
    expect_val("status_after_read", 80'h01);
    bus(2'd0, 4'h0);
    check_pop({72'h0, bus_if.DataOut_b});

    put_byte(KEY_OFFSET_TB()); cmd(4'd1);
    for (int i = 0; i < 10; i++) begin
      put_byte(key_bytes[i]);
      cmd(4'd4);
    end
    expect_val("key_value", 80'h1234567890ABCDEF00AA);
    check_pop(bus_if.Key_b);
    read_byte("key_read_zero", 8'h09, 8'h00);

    put_byte(8'h00); cmd(4'd1);
    for (int i = 0; i < 8; i++) begin
      put_byte(text_val[8*i +: 8]);
      cmd(4'd4);
    end
    expect_val("text_value", {16'h0, text_val});
    check_pop({16'h0, bus_if.PlainText_b});

    expect_val("start_pulse", 80'h1);
    cmd(4'd3);
    check_pop({79'h0, bus_if.Start});
    expect_val("start_single", 80'h0);
    bus(2'd0, 4'h0);
    check_pop({79'h0, bus_if.Start});

    bus_if.Ready = 1'b0;
    expect_val("status_busy", 80'h00);
    bus(2'd0, 4'h0);
    check_pop({72'h0, bus_if.DataOut_b});

    bus_if.Ready        = 1'b1;
    bus_if.Done         = 1'b1;
    bus_if.CipherText_b = ct_val;
    bus(2'd0, 4'h0);
    bus_if.Done         = 1'b0;
    bus_if.CipherText_b = 64'h0;
    expect_val("text_from_core", {16'h0, ct_val});
    check_pop({16'h0, bus_if.PlainText_b});
    expect_val("status_done", 80'h03);
    bus(2'd0, 4'h0);
    check_pop({72'h0, bus_if.DataOut_b});

    for (int i = 0; i < 8; i++) begin
      read_byte("ct_read", 8'(i), ct_val[8*i +: 8]);
    end

    bus_if.Ready = 1'b0;
    expect_val("start_busy_no_pulse", 80'h0);
    cmd(4'd3);
    check_pop({79'h0, bus_if.Start});
    expect_val("status_err", 80'h06);
    bus(2'd0, 4'h0);
    check_pop({72'h0, bus_if.DataOut_b});

    put_byte(8'h00); cmd(4'd1);
    put_byte(8'hFF); cmd(4'd2);
    expect_val("busy_write_dropped", {16'h0, ct_val});
    check_pop({16'h0, bus_if.PlainText_b});

    bus_if.Ready = 1'b1;
    cmd(4'd5);
    expect_val("status_cleared", 80'h01);
    bus(2'd0, 4'h0);
    check_pop({72'h0, bus_if.DataOut_b});

    put_byte(8'h00); cmd(4'd1);
    put_byte(8'hEE);
    bus_if.Done         = 1'b1;
    bus_if.CipherText_b = ct2_val;
    cmd(4'd2);
    bus_if.Done = 1'b0;
    expect_val("done_beats_write", {16'h0, ct2_val});
    check_pop({16'h0, bus_if.PlainText_b});
    expect_val("status_done_write", 80'h07);
    bus(2'd0, 4'h0);
    check_pop({72'h0, bus_if.DataOut_b});

    bus_if.Done = 1'b1;
    cmd(4'd5);
    bus_if.Done = 1'b0;
    expect_val("status_done_clear", 80'h03);
    bus(2'd0, 4'h0);
    check_pop({72'h0, bus_if.DataOut_b});

    put_byte(8'h20); cmd(4'd1);
    put_byte(8'h5A); cmd(4'd2);
    expect_val("test_before_reset", 80'h5A);
    bus(2'd1, 4'h3);
    check_pop({72'h0, bus_if.DataOut_b});
    #2 rst = 1'b1;
    #1;
    expect_val("midreset_dout", 80'h0);  check_pop({72'h0, bus_if.DataOut_b});
    expect_val("midreset_text", 80'h0);  check_pop({16'h0, bus_if.PlainText_b});
    expect_val("midreset_key", 80'h0);   check_pop(bus_if.Key_b);
    #2 rst = 1'b0;

    bus(2'd2, 4'h2); cmd(4'd1);
    expect_val("test_after_reset", 80'h00);
    bus(2'd1, 4'h0);
    check_pop({72'h0, bus_if.DataOut_b});
    bus(2'd2, 4'h9); cmd(4'd2);
    expect_val("high_only_write", 80'h90);
    bus(2'd1, 4'h0);
    check_pop({72'h0, bus_if.DataOut_b});
    read_byte("text_after_reset", 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic [7:0] KEY_OFFSET_TB();
    return 8'h08;
  endfunction

endmodule
